ct_iu_bju_pcfifo_ring: RTL and testbench

CT_IU_BJU_PCFIFO_RING -- requirements
Module: ct_iu_bju_pcfifo_ring

---
 rtl/ct_iu_bju_pcfifo_pkg.sv | 23 ++
 rtl/ct_iu_bju_pcfifo_ring_entry.sv | 66 ++++++
 rtl/ct_iu_bju_pcfifo_ring.sv | 87 ++++++++
 tb/tb_ct_iu_bju_pcfifo_ring.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ct_iu_bju_pcfifo_pkg.sv
// Shared sizing defaults and create_data field layout for the BJU PC FIFO ring.
// Field offsets are measured upward from bit PCW (the pc occupies [PCW-1:0]).
package ct_iu_bju_pcfifo_pkg;
  localparam int PCFIFO_DEPTH  = 8;
  localparam int PCFIFO_PCW    = 64;
  localparam int PCFIFO_CTRL_W = 11;

  localparam int OFS_CONDBR      = 0;
  localparam int OFS_PCALL       = 1;
  localparam int OFS_PRET        = 2;
  localparam int OFS_JMP         = 3;
  localparam int OFS_BHT_MISPRED = 4;
  localparam int OFS_BJU         = 5;
  localparam int OFS_BHT_PRED    = 6;
  localparam int OFS_LENGTH      = 7;
  localparam int OFS_VLD         = 8;
  localparam int OFS_FLUSH       = 9;
  localparam int OFS_CMPLT       = 10;

  function automatic int field_pos(input int pcw, input int ofs);
    return pcw + ofs;
  endfunction
endpackage

// File: rtl/ct_iu_bju_pcfifo_ring_entry.sv
// One PC FIFO slot: status bits (vld/cmplt/flush) plus the branch payload.
// Status and payload flops only toggle when their local enable fires.
module ct_iu_bju_pcfifo_ring_entry
  import ct_iu_bju_pcfifo_pkg::*;
#(
  parameter int PCW = PCFIFO_PCW,
  localparam int EW = PCW + PCFIFO_CTRL_W
) (
  input  logic          entry_clk,
  input  logic          cpurst_b,
  input  logic          create_en,
  input  logic [EW-1:0] create_data,
  input  logic          cmplt_en,
  input  logic          pop_en,
  input  logic          rtu_yy_xx_flush,
  input  logic          mark_flush,
  output logic [EW-1:0] entry_data
);
  localparam int PL_W = PCW + OFS_LENGTH + 1;

  logic            vld;
  logic            cmplt;
  logic            flush;
  logic [PL_W-1:0] payload;
  logic            ctrl_clk_en;
  logic            create_vld_bit;

  assign create_vld_bit = create_data[field_pos(PCW, OFS_VLD)];
  assign ctrl_clk_en = rtu_yy_xx_flush | create_en | pop_en | cmplt_en | mark_flush;

  // Global flush beats create beats retire; cmplt/mark only touch a live entry.
  always_ff @(posedge entry_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      vld   <= 1'b0;
      cmplt <= 1'b0;
      flush <= 1'b0;
    end else if (ctrl_clk_en) begin
      if (rtu_yy_xx_flush) begin
        vld   <= 1'b0;
        cmplt <= 1'b0;
        flush <= 1'b0;
      end else if (create_en) begin
        vld   <= create_vld_bit;
        cmplt <= create_data[field_pos(PCW, OFS_CMPLT)];
        flush <= create_data[field_pos(PCW, OFS_FLUSH)] | (mark_flush & create_vld_bit);
      end else if (pop_en) begin
        vld   <= 1'b0;
        cmplt <= 1'b0;
        flush <= 1'b0;
      end else begin
        if (cmplt_en && vld) cmplt <= 1'b1;
        if (mark_flush && vld) flush <= 1'b1;
      end
    end
  end

  always_ff @(posedge entry_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      payload <= '0;
    end else if (create_en) begin
      payload <= create_data[PL_W-1:0];
    end
  end

  assign entry_data = {cmplt, flush, vld, payload};
endmodule

// File: rtl/ct_iu_bju_pcfifo_ring.sv
// In-order ring of branch PC entries: allocate at tail, complete out of order
// by iid, retire from head once the head entry is complete.
module ct_iu_bju_pcfifo_ring
  import ct_iu_bju_pcfifo_pkg::*;
#(
  parameter int DEPTH = PCFIFO_DEPTH,
  parameter int PCW   = PCFIFO_PCW,
  localparam int EW    = PCW + PCFIFO_CTRL_W,
  localparam int AW    = $clog2(DEPTH),
  localparam int CNT_W = AW + 1
) (
  input  logic             entry_clk,
  input  logic             cpurst_b,
  input  logic             create_vld,
  input  logic [EW-1:0]    create_data,
  output logic             create_rdy,
  output logic [AW-1:0]    create_iid,
  input  logic             cmplt_vld,
  input  logic [AW-1:0]    cmplt_iid,
  input  logic             pop_req,
  output logic             pop_vld,
  output logic [EW-1:0]    pop_data,
  input  logic             rtu_yy_xx_flush,
  input  logic             iu_yy_xx_cancel,
  input  logic             rtu_iu_flush_fe,
  output logic [CNT_W-1:0] entry_cnt
);
  logic [AW-1:0]    head;
  logic [AW-1:0]    tail;
  logic [CNT_W-1:0] cnt;
  logic             full;
  logic             empty;
  logic             create_acc;
  logic             pop_acc;
  logic             mark_flush;
  logic [EW-1:0]    entry_data [DEPTH];
  logic [EW-1:0]    head_data;

  assign full  = (cnt == CNT_W'(DEPTH));
  assign empty = (cnt == '0);

  // A global flush swallows every same-cycle create, pop and mark.
  assign create_acc = create_vld & ~full & ~rtu_yy_xx_flush;
  assign pop_acc    = pop_req & pop_vld & ~rtu_yy_xx_flush;
  assign mark_flush = (iu_yy_xx_cancel | rtu_iu_flush_fe) & ~rtu_yy_xx_flush;

  always_ff @(posedge entry_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else if (rtu_yy_xx_flush) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (create_acc) tail <= tail + 1'b1;
      if (pop_acc)    head <= head + 1'b1;
      case ({create_acc, pop_acc})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    ct_iu_bju_pcfifo_ring_entry #(.PCW(PCW)) u_entry (
      .entry_clk       (entry_clk),
      .cpurst_b        (cpurst_b),
      .create_en       (create_acc & (tail == AW'(i))),
      .create_data     (create_data),
      .cmplt_en        (cmplt_vld & (cmplt_iid == AW'(i)) & ~rtu_yy_xx_flush),
      .pop_en          (pop_acc & (head == AW'(i))),
      .rtu_yy_xx_flush (rtu_yy_xx_flush),
      .mark_flush      (mark_flush),
      .entry_data      (entry_data[i])
    );
  end

  assign head_data  = entry_data[head];
  assign create_rdy = ~full;
  assign create_iid = tail;
  assign pop_vld    = ~empty & head_data[field_pos(PCW, OFS_VLD)] & head_data[field_pos(PCW, OFS_CMPLT)];
  assign pop_data   = head_data;
  assign entry_cnt  = cnt;
endmodule

// File: tb/tb_ct_iu_bju_pcfifo_ring.sv
// Bench for ct_iu_bju_pcfifo_ring: directed scenarios then random traffic,
// all checked against a queue-based model of the FIFO.
module tb_ct_iu_bju_pcfifo_ring;
  localparam int DEPTH = 8;
  localparam int PCW   = 64;
  localparam int EW    = PCW + 11;
  localparam int AW    = 3;
  localparam int VB    = PCW + 8;
  localparam int FB    = PCW + 9;
  localparam int CB    = PCW + 10;

  logic          entry_clk = 1'b0;
  logic          cpurst_b = 1'b0;
  logic          create_vld = 1'b0;
  logic [EW-1:0] create_data = '0;
  logic          create_rdy;
  logic [AW-1:0] create_iid;
  logic          cmplt_vld = 1'b0;
  logic [AW-1:0] cmplt_iid = '0;
  logic          pop_req = 1'b0;
  logic          pop_vld;
  logic [EW-1:0] pop_data;
  logic          rtu_yy_xx_flush = 1'b0;
  logic          iu_yy_xx_cancel = 1'b0;
  logic          rtu_iu_flush_fe = 1'b0;
  logic [AW:0]   entry_cnt;

  ct_iu_bju_pcfifo_ring #(.DEPTH(DEPTH), .PCW(PCW)) dut (
    .entry_clk       (entry_clk),
    .cpurst_b        (cpurst_b),
    .create_vld      (create_vld),
    .create_data     (create_data),
    .create_rdy      (create_rdy),
    .create_iid      (create_iid),
    .cmplt_vld       (cmplt_vld),
    .cmplt_iid       (cmplt_iid),
    .pop_req         (pop_req),
    .pop_vld         (pop_vld),
    .pop_data        (pop_data),
    .rtu_yy_xx_flush (rtu_yy_xx_flush),
    .iu_yy_xx_cancel (iu_yy_xx_cancel),
    .rtu_iu_flush_fe (rtu_iu_flush_fe),
    .entry_cnt       (entry_cnt)
  );

  always #5 entry_clk = ~entry_clk;

  typedef struct {
    logic [EW-1:0] d;
    int            iid;
  } ent_t;

  ent_t m_q[$];
  int   m_tail = 0;
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [EW-1:0] mk(input logic [PCW-1:0] pc, input logic [7:0] misc,
                                       input logic cm, input logic fl);
    return {cm, fl, 1'b1, misc, pc};
  endfunction

  task automatic check_model();
    logic exp_pv;
    exp_pv = (m_q.size() > 0) && m_q[0].d[VB] && m_q[0].d[CB];
    chk("entry_cnt", EW'(entry_cnt), EW'(m_q.size()));
    chk("create_rdy", EW'(create_rdy), EW'(m_q.size() < DEPTH));
    chk("create_iid", EW'(create_iid), EW'(m_tail));
    chk("pop_vld", EW'(pop_vld), EW'(exp_pv));
    if (m_q.size() > 0) chk("pop_data", pop_data, m_q[0].d);
  endtask

  // Drive one cycle of inputs, advance the model, then compare after the edge.
  task automatic cyc(input logic cv, input logic [EW-1:0] cd, input logic cmv,
                     input logic [AW-1:0] ci, input logic pr, input logic fl,
                     input logic ca, input logic fe);
    bit   c_acc;
    bit   p_acc;
    bit   mark;
    ent_t n;
    create_vld = cv; create_data = cd; cmplt_vld = cmv; cmplt_iid = ci;
    pop_req = pr; rtu_yy_xx_flush = fl; iu_yy_xx_cancel = ca; rtu_iu_flush_fe = fe;
    if (fl) begin
      m_q.delete();
      m_tail = 0;
    end else begin
      c_acc = cv && (m_q.size() < DEPTH);
      p_acc = pr && (m_q.size() > 0) && m_q[0].d[VB] && m_q[0].d[CB];
      mark  = ca || fe;
      foreach (m_q[k]) begin
        if (cmv && m_q[k].iid == int'(ci) && m_q[k].d[VB]) m_q[k].d[CB] = 1'b1;
        if (mark && m_q[k].d[VB]) m_q[k].d[FB] = 1'b1;
      end
      if (p_acc) void'(m_q.pop_front());
      if (c_acc) begin
        n.d = cd;
        if (mark && cd[VB]) n.d[FB] = 1'b1;
        n.iid = m_tail;
        m_q.push_back(n);
        m_tail = (m_tail + 1) % DEPTH;
      end
    end
    @(posedge entry_clk);
    @(negedge entry_clk);
    create_vld = 0; cmplt_vld = 0; pop_req = 0;
    rtu_yy_xx_flush = 0; iu_yy_xx_cancel = 0; rtu_iu_flush_fe = 0;
    check_model();
  endtask

  task automatic create(input logic [PCW-1:0] pc);
    cyc(1'b1, mk(pc, 8'h0, 1'b0, 1'b0), 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic complete(input int iid);
    cyc(1'b0, '0, 1'b1, AW'(iid), 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop();
    cyc(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic gflush();
    cyc(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    // reset values while cpurst_b is held low
    #3;
    chk("rst_create_rdy", EW'(create_rdy), EW'(1));
    chk("rst_create_iid", EW'(create_iid), '0);
    chk("rst_pop_vld", EW'(pop_vld), '0);
    chk("rst_pop_data", pop_data, '0);
    chk("rst_entry_cnt", EW'(entry_cnt), '0);
    @(negedge entry_clk);
    cpurst_b = 1'b1;

    // fill to full, then an extra create is dropped
    for (int i = 0; i < 8; i++) begin
      chk("fill_iid", EW'(create_iid), EW'(i));
      create(PCW'(64'h1000 + 4 * i));
    end
    chk("fill_cnt", EW'(entry_cnt), EW'(8));
    chk("fill_rdy", EW'(create_rdy), '0);
    create(PCW'(64'h2000));
    chk("fill_9th_cnt", EW'(entry_cnt), EW'(8));

    // out-of-order completion, in-order retire
    complete(1);
    chk("retire_wait", EW'(pop_vld), '0);
    complete(0);
    chk("retire_vld0", EW'(pop_vld), EW'(1));
    chk("retire_pc0", EW'(pop_data[PCW-1:0]), EW'(64'h1000));
    pop();
    chk("retire_pc1", EW'(pop_data[PCW-1:0]), EW'(64'h1004));
    pop();
    chk("retire_cnt", EW'(entry_cnt), EW'(6));

    // wrap-around of the tail pointer
    gflush();
    for (int i = 0; i < 8; i++) create(PCW'(64'h3000 + 4 * i));
    for (int i = 0; i < 3; i++) complete(i);
    for (int i = 0; i < 3; i++) pop();
    for (int i = 0; i < 3; i++) begin
      chk("wrap_iid", EW'(create_iid), EW'(i));
      create(PCW'(64'h3100 + 4 * i));
    end
    chk("wrap_cnt", EW'(entry_cnt), EW'(8));
    chk("wrap_head_pc", EW'(pop_data[PCW-1:0]), EW'(64'h300C));

    // full with completed head: pop wins, create dropped
    complete(3);
    cyc(1'b1, mk(PCW'(64'h4000), 8'h0, 1'b0, 1'b0), 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("fullsim_cnt", EW'(entry_cnt), EW'(7));
    chk("fullsim_iid", EW'(create_iid), EW'(3));

    // cancel marks every live entry, then a global flush beats a create
    gflush();
    for (int i = 0; i < 4; i++) create(PCW'(64'h5000 + 4 * i));
    cyc(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      complete(i);
      chk("cancel_flush_bit", EW'(pop_data[FB]), EW'(1));
      pop();
    end
    create(PCW'(64'h6000));
    cyc(1'b1, mk(PCW'(64'h6004), 8'h0, 1'b0, 1'b0), 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("gflush_cnt", EW'(entry_cnt), '0);
    chk("gflush_pop_vld", EW'(pop_vld), '0);
    chk("gflush_iid", EW'(create_iid), '0);

    // random traffic
    for (int t = 0; t < 600; t++) begin
      cyc(($urandom % 3) != 0,
          mk({$urandom, $urandom}, 8'($urandom), ($urandom % 8) == 0, ($urandom % 10) == 0),
          ($urandom % 2) == 0, AW'($urandom), ($urandom % 2) == 0,
          ($urandom % 60) == 0, ($urandom % 20) == 0, ($urandom % 25) == 0);
    end

    // asynchronous reset in the middle of a cycle
    gflush();
    for (int i = 0; i < 5; i++) create(PCW'(64'h7000 + 4 * i));
    #2;
    cpurst_b = 1'b0;
    #1;
    m_q.delete();
    m_tail = 0;
    chk("arst_cnt", EW'(entry_cnt), '0);
    chk("arst_pop_vld", EW'(pop_vld), '0);
    chk("arst_pop_data", pop_data, '0);
    @(negedge entry_clk);
    cpurst_b = 1'b1;
    chk("arst_next_iid", EW'(create_iid), '0);
    create(PCW'(64'h8000));
    chk("arst_first_pc", EW'(pop_data[PCW-1:0]), EW'(64'h8000));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
